// File: rtl/inert_intf_ctrl.sv
// Gyro interface sequencer: power-up delay, three config writes, then a low/high
// yaw-rate byte read through an external SPI monarch on every data-ready interrupt.
module inert_intf_ctrl #(
    parameter int INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] yaw_rt
);

    localparam logic [15:0] CMD_W1  = 16'h0D02;
    localparam logic [15:0] CMD_W2  = 16'h1160;
    localparam logic [15:0] CMD_W3  = 16'h1440;
    localparam logic [15:0] CMD_RDL = 16'hA600;
    localparam logic [15:0] CMD_RDH = 16'hA700;

    typedef enum logic [2:0] {
        S_INIT,
        S_W1,
        S_W2,
        S_W3,
        S_IDLE,
        S_RDL,
        S_RDH
    } state_t;

    state_t             r_state, w_state_next;
    logic [INIT_W-1:0]  r_timer, w_timer_next;
    logic               r_int_ff1, r_int_ff2;
    logic               r_snd, w_snd_next;
    logic [15:0]        r_cmd, w_cmd_next;
    logic               r_vld, w_vld_next;
    logic [15:0]        r_yaw, w_yaw_next;
    logic [7:0]         r_low, w_low_next;
    logic               w_done_ok;
    logic               w_unused_resp_hi;

    // A done coinciding with our own snd cannot belong to the new transaction.
    assign w_done_ok        = done & ~r_snd;
    assign w_unused_resp_hi = ^resp[15:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_timer   <= '0;
            r_int_ff1 <= 1'b0;
            r_int_ff2 <= 1'b0;
            r_snd     <= 1'b0;
            r_cmd     <= 16'h0000;
            r_vld     <= 1'b0;
            r_yaw     <= 16'h0000;
            r_low     <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_int_ff1 <= INT;
            r_int_ff2 <= r_int_ff1;
            r_snd     <= w_snd_next;
            r_cmd     <= w_cmd_next;
            r_vld     <= w_vld_next;
            r_yaw     <= w_yaw_next;
            r_low     <= w_low_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_snd_next   = 1'b0;
        w_cmd_next   = r_cmd;
        w_vld_next   = 1'b0;
        w_yaw_next   = r_yaw;
        w_low_next   = r_low;

        unique case (r_state)
            S_INIT: begin
                // Timer parks at all ones; leaving INIT is the only way it stops.
                if (&r_timer) begin
                    w_state_next = S_W1;
                    w_snd_next   = 1'b1;
                    w_cmd_next   = CMD_W1;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_W1: begin
                if (w_done_ok) begin
                    w_state_next = S_W2;
                    w_snd_next   = 1'b1;
                    w_cmd_next   = CMD_W2;
                end
            end
            S_W2: begin
                if (w_done_ok) begin
                    w_state_next = S_W3;
                    w_snd_next   = 1'b1;
                    w_cmd_next   = CMD_W3;
                end
            end
            S_W3: begin
                if (w_done_ok) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_int_ff2) begin
                    w_state_next = S_RDL;
                    w_snd_next   = 1'b1;
                    w_cmd_next   = CMD_RDL;
                end
            end
            S_RDL: begin
                if (w_done_ok) begin
                    w_low_next   = resp[7:0];
                    w_state_next = S_RDH;
                    w_snd_next   = 1'b1;
                    w_cmd_next   = CMD_RDH;
                end
            end
            S_RDH: begin
                if (w_done_ok) begin
                    w_yaw_next   = {resp[7:0], r_low};
                    w_vld_next   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    assign snd    = r_snd;
    assign cmd    = r_cmd;
    assign vld    = r_vld;
    assign yaw_rt = r_yaw;

endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Bench for inert_intf_ctrl: transaction-level reference model checked every cycle,
// a latency-programmable SPI monarch, directed scenarios and a randomized INT phase.
module tb_inert_intf_ctrl;

    localparam int W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        snd;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] yaw_rt;

    inert_intf_ctrl #(.INIT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .resp(resp),
        .snd(snd), .cmd(cmd), .vld(vld), .yaw_rt(yaw_rt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    // ---------------- reference model: transaction index + power-up edge count
    function automatic logic [15:0] cmd_of(input int k);
        case (k)
            0: return 16'h0D02;
            1: return 16'h1160;
            2: return 16'h1440;
            3: return 16'hA600;
            default: return 16'hA700;
        endcase
    endfunction

    int          m_edges;   // edges seen since reset release while powering up
    int          m_cur;     // outstanding transaction (0..2 writes, 3 low, 4 high), -1 none
    bit          m_ready;   // config writes finished
    bit          m_s1, m_s2, m_s2_old, m_snd_was;
    logic        m_snd = 1'b0, m_vld = 1'b0;
    logic [15:0] m_cmd = 16'h0000, m_yaw = 16'h0000;
    logic [7:0]  m_lo;

    task automatic m_issue(input int k);
        m_cur = k;
        m_snd = 1'b1;
        m_cmd = cmd_of(k);
    endtask

    always @(posedge clk) begin
        m_snd_was = m_snd;
        m_snd = 1'b0;
        m_vld = 1'b0;
        if (!rst_n) begin
            m_edges = 0; m_cur = -1; m_ready = 0; m_s1 = 0; m_s2 = 0;
            m_lo = 8'h00; m_yaw = 16'h0000; m_cmd = 16'h0000;
        end else begin
            m_s2_old = m_s2;
            m_s2 = m_s1;
            m_s1 = INT;
            if (!m_ready && m_cur < 0) begin
                // 2^W-1 edges to count up, one more to launch the first write
                m_edges++;
                if (m_edges == (1 << W)) m_issue(0);
            end else if (m_cur >= 0) begin
                if (done && !m_snd_was) begin
                    case (m_cur)
                        0, 1: m_issue(m_cur + 1);
                        2: begin m_cur = -1; m_ready = 1; end
                        3: begin m_lo = resp[7:0]; m_issue(4); end
                        default: begin
                            m_yaw = {resp[7:0], m_lo};
                            m_vld = 1'b1;
                            m_cur = -1;
                        end
                    endcase
                end
            end else if (m_s2_old) begin
                m_issue(3);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("snd", {31'd0, snd}, {31'd0, m_snd});
            check("cmd", {16'd0, cmd}, {16'd0, m_cmd});
            check("vld", {31'd0, vld}, {31'd0, m_vld});
            check("yaw_rt", {16'd0, yaw_rt}, {16'd0, m_yaw});
        end
    end

    // ---------------- transaction log
    logic [15:0] cmd_log[$];
    int snd_cnt = 0, vld_cnt = 0;

    always @(negedge clk) begin
        if (chk_en && snd) begin
            cmd_log.push_back(cmd);
            snd_cnt++;
            $display("cycle %0d: snd cmd=%h", cyc, cmd);
        end
        if (chk_en && vld) begin
            vld_cnt++;
            $display("cycle %0d: vld yaw_rt=%h", cyc, yaw_rt);
        end
    end

    // ---------------- SPI monarch model
    int          mon_lat = 20;
    bit          mon_rand = 1'b0;
    bit          fixed_mode = 1'b0;
    bit          force_done = 1'b0;
    logic [7:0]  fixed_lo = 8'h00, fixed_hi = 8'h00;
    int          mon_cnt = 0;
    logic [15:0] mon_resp = 16'h0000;

    always @(negedge clk) begin
        done = 1'b0;
        if (force_done) begin
            done = 1'b1;
            resp = 16'($urandom);
            force_done = 1'b0;
        end
        if (mon_cnt > 0) begin
            mon_cnt--;
            if (mon_cnt == 0) begin
                done = 1'b1;
                resp = mon_resp;
            end
        end
        if (snd) begin
            mon_cnt = mon_rand ? int'($urandom_range(25, 2)) : mon_lat;
            mon_resp = 16'($urandom);
            if (fixed_mode) mon_resp[7:0] = (cmd == 16'hA600) ? fixed_lo : fixed_hi;
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_snd(input string nm, input int lim);
        bit got = 1'b0;
        for (int n = 0; n < lim && !got; n++) begin
            tick();
            if (snd) got = 1'b1;
        end
        if (!got) timeout(nm);
    endtask

    task automatic wait_vld(input string nm, input int lim);
        bit got = 1'b0;
        for (int n = 0; n < lim && !got; n++) begin
            tick();
            if (vld) got = 1'b1;
        end
        if (!got) timeout(nm);
    endtask

    initial begin
        int cnt, rel, n0, v0;
        bit got;
        rst_n = 1'b0;
        INT = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        chk_en = 1'b1;
        check("rst_snd", {31'd0, snd}, 32'd0);
        check("rst_cmd", {16'd0, cmd}, 32'd0);
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_yaw", {16'd0, yaw_rt}, 32'd0);

        // power-up: INT high early must not shorten the delay
        rst_n = 1'b1;
        cnt = 0; got = 1'b0;
        while (!got && cnt < 1100) begin
            tick();
            cnt++;
            if (cnt == 100) INT = 1'b0;
            if (snd) got = 1'b1;
        end
        check("first_snd_edges", cnt, 1024);
        check("first_cmd", {16'd0, cmd}, 32'h0D02);

        wait_snd("w2_snd", 60);
        check("w2_cmd", {16'd0, cmd}, 32'h1160);
        INT = 1'b1;
        repeat (3) tick();
        INT = 1'b0;
        wait_snd("w3_snd", 60);
        check("w3_cmd", {16'd0, cmd}, 32'h1440);
        repeat (60) tick();
        check("idle_snd_cnt", snd_cnt, 3);
        force_done = 1'b1;
        repeat (10) tick();
        check("spurious_done_snd_cnt", snd_cnt, 3);
        check("log0", {16'd0, cmd_log[0]}, 32'h0D02);
        check("log1", {16'd0, cmd_log[1]}, 32'h1160);
        check("log2", {16'd0, cmd_log[2]}, 32'h1440);

        // directed read giving a negative yaw rate
        fixed_mode = 1'b1; fixed_lo = 8'h34; fixed_hi = 8'hF2;
        INT = 1'b1;
        wait_snd("rdl_snd", 10);
        check("rdl_cmd", {16'd0, cmd}, 32'hA600);
        INT = 1'b0;
        wait_snd("rdh_snd", 40);
        check("rdh_cmd", {16'd0, cmd}, 32'hA700);
        wait_vld("rd_vld", 40);
        check("yaw_f234", {16'd0, yaw_rt}, 32'hF234);
        tick();
        check("vld_one_cycle", {31'd0, vld}, 32'd0);
        repeat (40) tick();
        check("after_read_snd_cnt", snd_cnt, 5);

        // back-to-back reads with INT held high
        fixed_lo = 8'h7F; fixed_hi = 8'h01;
        INT = 1'b1;
        wait_vld("b2b_vld1", 120);
        tick();
        check("b2b_snd", {31'd0, snd}, 32'd1);
        check("b2b_cmd", {16'd0, cmd}, 32'hA600);
        check("b2b_yaw_hold", {16'd0, yaw_rt}, 32'h017F);
        wait_vld("b2b_vld2", 120);
        INT = 1'b0;
        repeat (100) tick();

        // randomized INT activity, monarch latency and response bytes
        fixed_mode = 1'b0;
        mon_rand = 1'b1;
        v0 = vld_cnt;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(19, 0) == 0) INT = ~INT;
            tick();
        end
        INT = 1'b0;
        repeat (100) tick();
        mon_rand = 1'b0;
        $display("random phase produced %0d reads", vld_cnt - v0);

        // reset during the high-byte read; its done lands 5 cycles later
        INT = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            tick();
            if (snd && cmd == 16'hA700) got = 1'b1;
        end
        if (!got) timeout("rdh_for_reset");
        INT = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rel = cyc;
        n0 = snd_cnt;
        v0 = vld_cnt;
        repeat (40) tick();
        check("reset_no_vld", vld_cnt, v0);
        check("reset_yaw_zero", {16'd0, yaw_rt}, 32'd0);
        check("reset_cmd_zero", {16'd0, cmd}, 32'd0);
        wait_snd("reinit_w1", 1100);
        check("reinit_delay", cyc - rel, 1024);
        check("reinit_cmd1", {16'd0, cmd}, 32'h0D02);
        wait_snd("reinit_w2", 60);
        check("reinit_cmd2", {16'd0, cmd}, 32'h1160);
        wait_snd("reinit_w3", 60);
        check("reinit_cmd3", {16'd0, cmd}, 32'h1440);
        repeat (40) tick();
        check("reinit_snd_cnt", snd_cnt - n0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
